// File: rtl/regfile_param.sv
// regfile_param -- parametrised register file with a hardware clear sequencer.
//
// Two registered read ports (A, B) and one write port. An optional
// hard-wired zero register and an optional write-first bypass are available.
// A registered debug tap mirrors one fixed entry. After reset, and on
// clear_req, a sequencer zeroes every entry, one per cycle. During that time
// ready is low, writes are dropped and all read outputs return 0. This lets
// the storage map onto plain RAM with no initialisation.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   write/wrAddr/wrData write port
//   rdAddrA/rdDataA     read port A (one-cycle latency)
//   rdAddrB/rdDataB     read port B (one-cycle latency)
//   dbg_data            registered view of entry DEBUG_ADDR
//   clear_req           single-cycle request to zero the whole file
//   ready               high once the file holds valid, usable contents
//   wr_dropped          one-cycle pulse for each discarded write
module regfile_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter int DEBUG_ADDR = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataB,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              clear_req,
  output logic              ready,
  output logic              wr_dropped
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;
  localparam logic [ADDR_W-1:0] DBG_PTR  = ADDR_W'(DEBUG_ADDR);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_commit;
  logic              drop_d;
  logic [DATA_W-1:0] rd_a_d, rd_b_d, dbg_d;

  // A write lands only in RUN, when no clear is being requested, and when the
  // target is not the hard-wired zero entry.
  assign wr_commit = (state_q == RUN) && write && !clear_req &&
                     !(ZERO_REG && (wrAddr == '0));

  // Writing to the zero entry is an architectural no-op, not a dropped write.
  assign drop_d = write && ((state_q == CLEAR) || clear_req);

  assign ready = (state_q == RUN);

  // Next-read value for one port. Bypass rides on wr_commit, so reads that
  // coincide with a clear request return pre-clear memory.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (state_q == CLEAR)                            return '0;
    if (ZERO_REG && (addr == '0))                    return '0;
    if (BYPASS && wr_commit && (wrAddr == addr))     return wrData;
    return mem[addr];
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    rd_a_d    = read_port(rdAddrA);
    rd_b_d    = read_port(rdAddrB);
    dbg_d     = read_port(DBG_PTR);
    unique case (state_q)
      CLEAR: begin
        // Pointer wraps to 0 naturally on the final entry.
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_PTR) state_d = RUN;
      end
      RUN: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      rdDataA    <= '0;
      rdDataB    <= '0;
      dbg_data   <= '0;
      wr_dropped <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rdDataA    <= rd_a_d;
      rdDataB    <= rd_b_d;
      dbg_data   <= dbg_d;
      wr_dropped <= drop_d;
    end
  end

  // NOTE: the array has no reset branch so it maps onto RAM; the clear
  // sequencer is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_commit) begin
      mem[wrAddr] <= wrData;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param. Drives two instances at once:
//   u0: defaults (32-bit, 32 entries, zero register, bypass, tap on 15)
//   u1: 16-bit, 8 entries, no zero register, read-first, tap on 5
// The reference model keeps a plain array per instance and applies the
// read/write/clear rules directly. Every cycle it predicts each output.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus, index 0 -> u0, index 1 -> u1
  logic        rst [2];
  logic        wr  [2];
  logic        cr  [2];
  logic [31:0] wa  [2];
  logic [31:0] wd  [2];
  logic [31:0] ra  [2];
  logic [31:0] rb  [2];

  logic [31:0] a0, b0, d0;
  logic        rdy0, drop0;
  logic [15:0] a1, b1, d1;
  logic        rdy1, drop1;

  regfile_param u0 (
    .clk(clk), .rst_n(rst[0]), .write(wr[0]), .wrAddr(wa[0][4:0]),
    .wrData(wd[0]), .rdAddrA(ra[0][4:0]), .rdDataA(a0),
    .rdAddrB(rb[0][4:0]), .rdDataB(b0), .dbg_data(d0),
    .clear_req(cr[0]), .ready(rdy0), .wr_dropped(drop0)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0),
                  .DEBUG_ADDR(5)) u1 (
    .clk(clk), .rst_n(rst[1]), .write(wr[1]), .wrAddr(wa[1][2:0]),
    .wrData(wd[1][15:0]), .rdAddrA(ra[1][2:0]), .rdDataA(a1),
    .rdAddrB(rb[1][2:0]), .rdDataB(b1), .dbg_data(d1),
    .clear_req(cr[1]), .ready(rdy1), .wr_dropped(drop1)
  );

  // ---------------- reference model ----------------
  int dw   [2] = '{32, 16};
  int aw   [2] = '{5, 3};
  bit zr   [2] = '{1'b1, 1'b0};
  bit byp  [2] = '{1'b1, 1'b0};
  int dbga [2] = '{15, 5};

  logic [31:0] mm [2][32];
  bit          in_clear [2];
  int          clr_cnt  [2];
  logic [31:0] ea [2], eb [2], ed [2];
  bit          erdy [2], edrop [2];

  function automatic logic [31:0] dmask(int i);
    logic [63:0] m;
    m = (64'd1 << dw[i]) - 64'd1;
    return m[31:0];
  endfunction

  function automatic int amask(int i);
    return (1 << aw[i]) - 1;
  endfunction

  function automatic logic [31:0] mread(int i, int addr, bit commit, int w, logic [31:0] data);
    if (zr[i] && addr == 0) return 32'h0;
    if (byp[i] && commit && w == addr) return data & dmask(i);
    return mm[i][addr];
  endfunction

  task automatic model_reset(int i);
    in_clear[i] = 1'b1;
    clr_cnt[i]  = 0;
    ea[i] = 32'h0; eb[i] = 32'h0; ed[i] = 32'h0;
    erdy[i] = 1'b0; edrop[i] = 1'b0;
  endtask

  task automatic model_edge(int i);
    int w, x, y;
    bit commit;
    if (!rst[i]) begin
      model_reset(i);
      return;
    end
    w = int'(wa[i]) & amask(i);
    x = int'(ra[i]) & amask(i);
    y = int'(rb[i]) & amask(i);
    if (in_clear[i]) begin
      ea[i] = 32'h0; eb[i] = 32'h0; ed[i] = 32'h0;
      edrop[i] = wr[i];
      mm[i][clr_cnt[i]] = 32'h0;
      clr_cnt[i]++;
      if (clr_cnt[i] == (1 << aw[i])) begin
        in_clear[i] = 1'b0;
        clr_cnt[i]  = 0;
      end
    end else begin
      commit   = wr[i] && !cr[i] && !(zr[i] && w == 0);
      ea[i]    = mread(i, x, commit, w, wd[i]);
      eb[i]    = mread(i, y, commit, w, wd[i]);
      ed[i]    = mread(i, dbga[i], commit, w, wd[i]);
      edrop[i] = wr[i] && cr[i];
      if (cr[i]) begin
        in_clear[i] = 1'b1;
        clr_cnt[i]  = 0;
      end else if (commit) begin
        mm[i][w] = wd[i] & dmask(i);
      end
    end
    erdy[i] = !in_clear[i];
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(string tag);
    check({tag, "/u0.rdDataA"}, a0, ea[0]);
    check({tag, "/u0.rdDataB"}, b0, eb[0]);
    check({tag, "/u0.dbg"}, d0, ed[0]);
    check({tag, "/u0.ready"}, {31'h0, rdy0}, {31'h0, erdy[0]});
    check({tag, "/u0.drop"}, {31'h0, drop0}, {31'h0, edrop[0]});
    check({tag, "/u1.rdDataA"}, {16'h0, a1}, ea[1]);
    check({tag, "/u1.rdDataB"}, {16'h0, b1}, eb[1]);
    check({tag, "/u1.dbg"}, {16'h0, d1}, ed[1]);
    check({tag, "/u1.ready"}, {31'h0, rdy1}, {31'h0, erdy[1]});
    check({tag, "/u1.drop"}, {31'h0, drop1}, {31'h0, edrop[1]});
  endtask

  // One clock: inputs already set; sample 1 time unit after the edge.
  task automatic step(string tag);
    @(posedge clk);
    #1;
    model_edge(0);
    model_edge(1);
    compare_all(tag);
  endtask

  task automatic idle(int i);
    wr[i] = 1'b0; cr[i] = 1'b0;
    wa[i] = 32'h0; wd[i] = 32'h0; ra[i] = 32'h0; rb[i] = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 32; j++) mm[i][j] = 32'h0;
      rst[i] = 1'b1;
      idle(i);
    end

    // Reset both instances, then release between edges.
    #2;
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    model_reset(0); model_reset(1);
    compare_all("reset");
    step("in_reset");
    step("in_reset");
    rst[0] = 1'b1; rst[1] = 1'b1;

    // Clear after reset: ready low for 31 edges (u0), 7 edges (u1).
    for (int k = 1; k <= 32; k++) begin
      step("init_clear");
      if (k == 7)  check("u1_ready_edge7", {31'h0, rdy1}, 32'h0);
      if (k == 8)  check("u1_ready_edge8", {31'h0, rdy1}, 32'h1);
      if (k == 31) check("u0_ready_edge31", {31'h0, rdy0}, 32'h0);
      if (k == 32) check("u0_ready_edge32", {31'h0, rdy0}, 32'h1);
    end

    // Every entry reads 0 on both ports.
    for (int k = 0; k < 33; k++) begin
      ra[0] = 32'(k % 32); rb[0] = 32'(31 - (k % 32));
      ra[1] = 32'(k % 8);  rb[1] = 32'(7 - (k % 8));
      step("read_all_zero");
    end
    idle(0); idle(1);

    // Write then read r7; write r0 is discarded silently.
    wr[0] = 1'b1; wa[0] = 7; wd[0] = 32'hDEADBEEF;
    step("wr_r7");
    wr[0] = 1'b0; ra[0] = 7;
    step("rd_r7");
    check("r7_readback", a0, 32'hDEADBEEF);
    wr[0] = 1'b1; wa[0] = 0; wd[0] = 32'h12345678; ra[0] = 0;
    step("wr_r0");
    wr[0] = 1'b0;
    step("rd_r0");
    check("r0_reads_zero", a0, 32'h0);
    check("r0_no_drop", {31'h0, drop0}, 32'h0);

    // Collision: u0 bypasses, u1 returns old data.
    wr[0] = 1'b1; wa[0] = 9; wd[0] = 32'h1;
    wr[1] = 1'b1; wa[1] = 1; wd[1] = 32'h1;
    step("coll_setup");
    wd[0] = 32'hA5A5A5A5; ra[0] = 9; rb[0] = 9;
    wd[1] = 32'hA5A5;     ra[1] = 1; rb[1] = 1;
    step("collision");
    check("u0_coll_A", a0, 32'hA5A5A5A5);
    check("u0_coll_B", b0, 32'hA5A5A5A5);
    check("u1_coll_A", {16'h0, a1}, 32'h1);
    check("u1_coll_B", {16'h0, b1}, 32'h1);
    wr[0] = 1'b0; wr[1] = 1'b0;
    step("coll_after");
    check("u1_after_coll", {16'h0, a1}, 32'hA5A5);

    // Debug tap.
    wr[0] = 1'b1; wa[0] = 15; wd[0] = 32'h0000F00D; ra[0] = 15;
    step("dbg_wr15");
    check("dbg_f00d", d0, 32'h0000F00D);
    check("dbg_bypass_rd", a0, 32'h0000F00D);
    wa[0] = 14; wd[0] = 32'h11112222;
    step("dbg_wr14");
    check("dbg_unchanged", d0, 32'h0000F00D);

    // clear_req with a write of r3.
    wa[0] = 3; wd[0] = 32'h55; cr[0] = 1'b1;
    step("clear_req");
    check("clr_ready_low", {31'h0, rdy0}, 32'h0);
    check("clr_drop", {31'h0, drop0}, 32'h1);
    cr[0] = 1'b0;
    for (int k = 0; k < 32; k++) begin
      wr[0] = (k % 3 == 0); wa[0] = 32'($urandom_range(0, 31)); wd[0] = $urandom;
      cr[0] = (k == 5);
      step("during_clear");
    end
    idle(0);
    check("clr_ready_high", {31'h0, rdy0}, 32'h1);
    ra[0] = 3; rb[0] = 15;
    step("post_clear_rd");
    check("post_clear_r3", a0, 32'h0);
    check("post_clear_r15", b0, 32'h0);

    // u1: entry 0 is ordinary storage; reset mid-clear restarts it.
    wr[1] = 1'b1; wa[1] = 0; wd[1] = 32'hBEEF;
    step("u1_wr_r0");
    wr[1] = 1'b0; ra[1] = 0;
    step("u1_rd_r0");
    check("u1_r0_beef", {16'h0, a1}, 32'hBEEF);
    cr[1] = 1'b1;
    step("u1_clear");
    cr[1] = 1'b0;
    step("u1_midclear");
    step("u1_midclear");
    rst[1] = 1'b0;
    #1;
    model_reset(1);
    compare_all("u1_async_rst");
    step("u1_in_rst");
    rst[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step("u1_reclear");
      if (k == 7) check("u1_reclear_edge7", {31'h0, rdy1}, 32'h0);
      if (k == 8) check("u1_reclear_edge8", {31'h0, rdy1}, 32'h1);
    end
    ra[1] = 0;
    step("u1_r0_cleared");
    check("u1_r0_zero", {16'h0, a1}, 32'h0);

    // Randomized traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        wr[i] = 1'($urandom_range(0, 1));
        wa[i] = 32'($urandom_range(0, 31));
        wd[i] = $urandom;
        ra[i] = ($urandom_range(0, 3) == 0) ? wa[i] : 32'($urandom_range(0, 31));
        rb[i] = ($urandom_range(0, 3) == 0) ? wa[i] : 32'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) wa[i] = 32'(dbga[i]);
        cr[i] = ($urandom_range(0, 59) == 0);
      end
      step("random");
    end
    idle(0); idle(1);
    step("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the processor's 32x32 register file.
- Configurable data width and depth, with a selectable hard-wired zero register.
- Optional write-to-read bypass for same-cycle collisions.
- Registered debug tap on one fixed entry; the board LED display consumes it.
- Hardware clear sequencer runs after reset and on request, so the file needs no initial-block initialisation and synthesises to plain RAM plus one counter.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1, entry 0 always reads as 0 and writes to it are discarded.
- BYPASS, 1, when 1, a read of the entry being written in the same cycle returns the new data (write-first); when 0, it returns the old data (read-first).
- DEBUG_ADDR, 15, entry mirrored on dbg_data; must be < DEPTH.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- write  in  1  write enable.
- wrAddr  in  ADDR_W  write address.
- wrData  in  DATA_W  write data.
- rdAddrA  in  ADDR_W  read port A address.
- rdDataA  out  DATA_W  read port A data, registered.
- rdAddrB  in  ADDR_W  read port B address.
- rdDataB  out  DATA_W  read port B data, registered.
- dbg_data  out  DATA_W  registered copy of entry DEBUG_ADDR.
- clear_req  in  1  single-cycle request to zero the whole file.
- ready  out  1  high when the file accepts writes and returns stored data.
- wr_dropped  out  1  one-cycle pulse when an asserted write was discarded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdDataA, rdDataB, dbg_data = 0; ready = 0; wr_dropped = 0.
  - State = CLEAR; clear pointer clr_ptr = 0.
  - Memory contents are not reset directly.
- State machine has two states, CLEAR and RUN.
- CLEAR:
  - Each rising edge writes 0 to mem[clr_ptr] and increments clr_ptr.
  - On the edge that writes entry DEPTH-1, clr_ptr wraps to 0, the state goes to RUN and ready goes to 1, all on that same edge.
  - A full clear therefore takes exactly DEPTH cycles. After rst_n deasserts, ready is high following the DEPTH-th rising edge.
  - While in CLEAR, rdDataA, rdDataB and dbg_data register 0 every cycle.
  - write is ignored; if write=1 on an edge, wr_dropped=1 on the next cycle.
  - clear_req is ignored; the clear does not restart.
- RUN:
  - A write commits mem[wrAddr] = wrData at the edge where write=1.
  - Exception: if ZERO_REG=1 and wrAddr=0, nothing is stored and wr_dropped is not pulsed (architectural no-op).
  - Reads have 1-cycle latency: rdDataX at edge N+1 reflects rdAddrX sampled at edge N.
  - If ZERO_REG=1 and rdAddrX=0, rdDataX = 0 regardless of memory contents.
  - Collision (write=1, wrAddr==rdAddrX, entry writable): BYPASS=1 gives rdDataX = wrData; BYPASS=0 gives the pre-write contents.
  - Ports A and B are independent; both may address the same entry.
  - dbg_data follows the same rules as a read port with fixed address DEBUG_ADDR, including the bypass and zero rules.
- clear_req=1 in RUN:
  - On the next edge, state = CLEAR, ready = 0, clr_ptr = 0.
  - clear_req has priority: a write on that same edge is not committed and wr_dropped pulses.
  - Reads on that edge still return pre-clear data (bypass not applied).
- wr_dropped is registered, high for exactly one cycle per dropped write, and 0 otherwise.
- Reset asserted mid-clear or mid-RUN: immediate return to the reset values above. A full DEPTH-cycle clear restarts after release.
- Width rules:
  - No arithmetic beyond clr_ptr, which is ADDR_W bits and wraps naturally.
  - Addresses are always in range since DEPTH = 2**ADDR_W.

Test Plan:
1. Reset release with defaults: ready low for 31 edges, high after edge 32. Then read all 32 entries on A and B; every result = 0x00000000.
2. Write 0xDEADBEEF to r7, then the next cycle read r7 on A: rdDataA = 0xDEADBEEF one cycle later. Write 0x12345678 to r0 and read r0: result 0, wr_dropped stays 0.
3. Collision: write r9 = 0xA5A5A5A5 while rdAddrA = rdAddrB = 9 (old value 0x1).
   - BYPASS=1: both ports give 0xA5A5A5A5.
   - BYPASS=0: both give 0x1; the following read gives 0xA5A5A5A5.
4. Debug tap: write r15 = 0x0000F00D; dbg_data = 0x0000F00D one cycle later (same edge as a bypassed read). A write to r14 leaves dbg_data unchanged.
5. clear_req asserted together with a write of r3 = 0x55:
   - ready = 0 next cycle and wr_dropped pulses once.
   - Writes during CLEAR each pulse wr_dropped.
   - After 32 cycles ready = 1 and r3 and r15 read 0.
6. Parametrisation (DATA_W=16, ADDR_W=3, ZERO_REG=0): ready after 8 edges; r0 holds 0xBEEF. Asserting rst_n low mid-clear restarts an 8-cycle clear after release.
